byte_to_smp: RTL
================

# byte_to_smp

Reassembles a stream of 8-bit packets into words of arbitrary width. The packets arrive from the ILA SPI slave receive path. This block is the inverse of the sample-to-byte splitter on the readout path. It delivers host-written configuration and trigger-pattern words to the ILA control logic over a valid/ready handshake. Byte order on the link is LSB-packet first; unused pad bits in the last packet are discarded.

## Interface

- `word_width`, 24, width of the reassembled word; must be ≥1.
- `timeout_cycles`, 1024, idle cycles after which a partial word is aborted; used only with `B2W_TIMEOUT_EN`; must be ≥2.

- `i_clk_ILA`  in  1  ILA clock; all logic on the rising edge.
- `i_rst_n`  in  1  reset, asynchronous assert, active-low; one clock, reset asynchronous and active-low.
- `i_frame_active`  in  1  high while the host transfer (chip select) is active; low aborts assembly.
- `i_byte`  in  8  received packet.
- `i_slave_end_byte_post_edge`  in  1  one-cycle strobe: `i_byte` is valid this cycle.
- `o_word`  out  word_width  assembled word; stable while `o_word_valid`.
- `o_word_valid`  out  1  word available; held until accepted.
- `i_word_ready`  in  1  consumer accepts `o_word` in any cycle where it is high together with `o_word_valid`.
- `o_busy`  out  1  partial word in progress (`byte_cnt != 0`).
- `o_overrun`  out  1  sticky: a completed word was dropped.
- `o_timeout`  out  1  one-cycle pulse when a partial word is aborted by timeout.

## Operation

- `bytes_per_word = ((word_width-1)/8)+1`.
- Counter width: `max(1, $clog2(bytes_per_word))`.
- Assembly register `asm_reg`, `bytes_per_word*8` bits.
- Byte strobe, frame active:
  - `asm_reg <= {i_byte, asm_reg[top:8]}`.
  - `byte_cnt` increments.
- Completion = strobe while `byte_cnt == bytes_per_word-1`, frame active.
  - `byte_cnt` returns to 0.
  - Candidate word is `{i_byte, asm_reg[top:8]}[word_width-1:0]`.
- Output slot has two states, EMPTY and FULL:
  - EMPTY + completion → load `o_word`, go to FULL.
  - FULL + ready, no completion → EMPTY.
  - FULL + ready + completion → load the new word, stay FULL (back-to-back, no bubble).
  - FULL + no ready + completion → new word dropped, `o_word` unchanged, `o_overrun <= 1`.
- `o_overrun` is cleared only by reset.
- `i_frame_active` low:
  - `byte_cnt <= 0` and `asm_reg <= 0`.
  - Strobes are ignored.
  - Output slot and `o_overrun` are unaffected.
- `bytes_per_word == 1`: every strobe is a completion.
- Pad bits (`bytes_per_word*8 - word_width` MSBs of the last packet) are dropped; no check is made on them.

## Timing

- Reset values: `o_word = 0`, `o_word_valid = 0`, `o_busy = 0`, `o_overrun = 0`, `o_timeout = 0`, `byte_cnt = 0`, `asm_reg = 0`.
- Latency: completing strobe in cycle N → `o_word_valid` high and `o_word` updated in cycle N+1.
- `o_word_valid` falls the cycle after acceptance unless a completion occurs in the acceptance cycle.
- `o_busy` is registered and reflects `byte_cnt` one cycle after each strobe.
- Strobes may arrive on consecutive cycles; full throughput is one packet per cycle.
- Reset mid-word or mid-handshake returns everything to reset values immediately (asynchronously); the partial word is lost.
- `o_overrun` asserts in cycle N+1 after the dropped completion.

## Configuration

- `B2W_TIMEOUT_EN` defined:
  - An idle counter runs while `byte_cnt != 0`; it clears on every strobe and whenever `byte_cnt == 0`.
  - When it reaches `timeout_cycles-1`, on the next edge: `byte_cnt <= 0`, `asm_reg <= 0`, `o_timeout` pulses high for one cycle.
  - A strobe in the same cycle as expiry wins: it is accepted and the counter clears.
- `B2W_TIMEOUT_EN` not defined:
  - No counter is built and `o_timeout` is tied 0.
  - A partial word waits indefinitely, until completion, frame drop or reset.

## Test plan

- `word_width=24`: strobes 0x11, 0x22, 0x33 on consecutive cycles, ready high → `o_word=0x332211`, `o_word_valid` high exactly one cycle after the 3rd strobe, low the cycle after.
- `word_width=20`: bytes 0xAB, 0xCD, 0xFE → `o_word=0xECDAB` (pad nibble 0xF dropped); `o_busy` 1 after bytes 1–2, 0 after byte 3.
- `word_width=24`, ready held low: send 0x010203 then 0x040506 → `o_word` stays 0x010203, `o_overrun=1`. Raise ready with a third word completing the same cycle → `o_word=0x070809`, valid stays 1.
- `word_width=24`: bytes 0xAA, 0xBB, drop `i_frame_active` one cycle, then 0x01, 0x02, 0x03 → `o_word=0x030201`, no overrun.
- `B2W_TIMEOUT_EN`, `timeout_cycles=16`: one byte 0x55, then idle → `o_timeout` pulses once, `o_busy=0`. Next 3 bytes 0x01, 0x02, 0x03 → `0x030201`. Without the macro, no pulse and `o_busy` stays 1.
- Assert `i_rst_n` low after 2 of 3 bytes with `o_word_valid=1` → all outputs 0 at once; 3 fresh bytes after release assemble correctly.

Source files
------------

// File: rtl/byte_to_smp_if.sv
// byte_to_smp_if: packet-in / word-out bundle for the byte_to_smp reassembler.
// The slave modport is the reassembler side; the master modport is the side
// that feeds packets and consumes words.
interface byte_to_smp_if #(
  parameter int word_width = 24
) ();
  logic                  i_frame_active;
  logic [7:0]            i_byte;
  logic                  i_slave_end_byte_post_edge;
  logic [word_width-1:0] o_word;
  logic                  o_word_valid;
  logic                  i_word_ready;
  logic                  o_busy;
  logic                  o_overrun;
  logic                  o_timeout;

  modport master (
    output i_frame_active, i_byte, i_slave_end_byte_post_edge, i_word_ready,
    input  o_word, o_word_valid, o_busy, o_overrun, o_timeout
  );

  modport slave (
    input  i_frame_active, i_byte, i_slave_end_byte_post_edge, i_word_ready,
    output o_word, o_word_valid, o_busy, o_overrun, o_timeout
  );
endinterface

// File: rtl/byte_to_smp.sv
// byte_to_smp: reassembles LSB-first 8-bit packets from the SPI receive path
// into word_width-bit words and offers them on a valid/ready output slot.
// Optional partial-word abort on idle: define B2W_TIMEOUT_EN.
module byte_to_smp #(
  parameter int word_width     = 24,
  parameter int timeout_cycles = 1024
) (
  input  logic         i_clk_ILA,
  input  logic         i_rst_n,
  byte_to_smp_if.slave bus
);
  localparam int BPW = ((word_width - 1) / 8) + 1;
  localparam int CW  = (BPW > 1) ? $clog2(BPW) : 1;
  localparam int AW  = BPW * 8;
  localparam logic [CW-1:0] LAST = CW'(BPW - 1);

  // Reject configurations that cannot work at elaboration time.
  generate
    if (word_width < 1) begin : g_bad_width
      $error("byte_to_smp: word_width must be >= 1");
    end
    if (timeout_cycles < 2) begin : g_bad_timeout
      $error("byte_to_smp: timeout_cycles must be >= 2");
    end
  endgenerate

  logic [CW-1:0]         r_byte_cnt;
  logic [AW-1:0]         r_asm;
  logic [word_width-1:0] r_word;
  logic                  r_word_valid;
  logic                  r_busy;
  logic                  r_overrun;
  logic                  w_strobe;
  logic                  w_complete;
  logic                  w_expire;
  logic                  w_timeout;
  logic [AW-1:0]         w_shifted;
  logic [word_width-1:0] w_candidate;

  // Strobes outside an active frame are ignored entirely.
  assign w_strobe   = bus.i_slave_end_byte_post_edge & bus.i_frame_active;
  assign w_complete = w_strobe && (r_byte_cnt == LAST);

  // New packet enters at the top, so the first packet ends up in the LSBs.
  generate
    if (BPW == 1) begin : g_single
      assign w_shifted = bus.i_byte;
    end else begin : g_multi
      assign w_shifted = {bus.i_byte, r_asm[AW-1:8]};
    end
  endgenerate

  // Pad bits in the last packet fall off the top here.
  assign w_candidate = w_shifted[word_width-1:0];

`ifdef B2W_TIMEOUT_EN
  localparam int IW = $clog2(timeout_cycles);
  logic [IW-1:0] r_idle;
  logic          r_timeout;

  // A strobe in the expiry cycle wins, so expiry requires no strobe.
  assign w_expire  = bus.i_frame_active && (r_byte_cnt != '0) && !w_strobe &&
                     (r_idle == IW'(timeout_cycles - 1));
  assign w_timeout = r_timeout;

  // Idle counter runs only while a partial word is pending; one-cycle abort pulse.
  always_ff @(posedge i_clk_ILA or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_idle    <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= w_expire;
      if (w_strobe || w_expire || !bus.i_frame_active || (r_byte_cnt == '0))
        r_idle <= '0;
      else
        r_idle <= r_idle + 1'b1;
    end
  end
`else
  // Without the abort a partial word waits for completion, frame drop or reset.
  assign w_expire  = 1'b0;
  assign w_timeout = 1'b0;
`endif

  // Assembly shift register and packet counter; o_busy mirrors the next count.
  always_ff @(posedge i_clk_ILA or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_byte_cnt <= '0;
      r_asm      <= '0;
      r_busy     <= 1'b0;
    end else if (!bus.i_frame_active || w_expire) begin
      r_byte_cnt <= '0;
      r_asm      <= '0;
      r_busy     <= 1'b0;
    end else if (w_strobe) begin
      r_asm <= w_shifted;
      if (w_complete) begin
        r_byte_cnt <= '0;
        r_busy     <= 1'b0;
      end else begin
        r_byte_cnt <= r_byte_cnt + 1'b1;
        r_busy     <= 1'b1;
      end
    end
  end

  // Single-entry output slot: load when empty or being drained, else drop and flag.
  always_ff @(posedge i_clk_ILA or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_word       <= '0;
      r_word_valid <= 1'b0;
      r_overrun    <= 1'b0;
    end else if (!r_word_valid) begin
      if (w_complete) begin
        r_word       <= w_candidate;
        r_word_valid <= 1'b1;
      end
    end else if (bus.i_word_ready) begin
      if (w_complete)
        r_word <= w_candidate;
      else
        r_word_valid <= 1'b0;
    end else if (w_complete) begin
      r_overrun <= 1'b1;
    end
  end

  assign bus.o_word       = r_word;
  assign bus.o_word_valid = r_word_valid;
  assign bus.o_busy       = r_busy;
  assign bus.o_overrun    = r_overrun;
  assign bus.o_timeout    = w_timeout;
endmodule
